// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle control sequencer for the 16-bit CPU datapath. Each instruction
// walks FETCH -> DECODE -> EXECUTE -> (WRITEBACK) and then retires. The block
// drives the datapath strobes (RAM read, IR load, register-file read/write,
// PC advance/load), supports free-running (run) and single-step (step)
// operation, parks in HALT on a decoded HALT instruction and counts retired
// instructions.
//
// Parameters
//   FETCH_WAIT   RAM read latency in cycles (1..4)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   run           level: issue instructions back-to-back while high
//   step          one-cycle pulse: issue one instruction from IDLE when run=0
//   dec_writes    decoded instruction writes a register
//   dec_jump      decoded instruction is an unconditional jump
//   dec_branch    decoded instruction is a conditional branch
//   dec_halt      decoded instruction is HALT
//   branch_check  ALU branch condition, valid during EXECUTE
//   ram_read      RAM read strobe
//   ir_load       capture RAM output into the instruction register
//   reg_read      register-file read enable
//   reg_write     register-file write enable
//   pc_inc        advance PC by one
//   pc_load       load PC from the jump/branch target
//   halted        sequencer is in HALT
//   state         current state encoding (debug)
//   instr_count   number of retired instructions (wraps)
// ---------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int FETCH_WAIT = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             dec_writes,
    input  logic             dec_jump,
    input  logic             dec_branch,
    input  logic             dec_halt,
    input  logic             branch_check,
    output logic             ram_read,
    output logic             ir_load,
    output logic             reg_read,
    output logic             reg_write,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    // Wait counter only has to reach FETCH_WAIT-1, which is at most 3.
    localparam logic [1:0] WAIT_LAST = 2'(FETCH_WAIT - 1);

    state_t            state_q, state_d;
    logic [1:0]        wait_q, wait_d;
    logic              single_q, single_d;
    logic [CNT_W-1:0]  count_q;
    logic              retire;
    logic              last_fetch;
    logic              take_pc_load;

    assign last_fetch   = (wait_q == WAIT_LAST);
    // Jump wins over branch: a jump loads the PC regardless of the condition.
    assign take_pc_load = dec_jump | (dec_branch & branch_check);

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d   = state_q;
        wait_d    = wait_q;
        single_d  = single_q;
        retire    = 1'b0;
        ram_read  = 1'b0;
        ir_load   = 1'b0;
        reg_read  = 1'b0;
        reg_write = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        halted    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end else if (step) begin
                    state_d  = S_FETCH;
                    wait_d   = '0;
                    single_d = 1'b1;
                end
            end

            S_FETCH: begin
                ram_read = 1'b1;
                if (last_fetch) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end

            S_DECODE: begin
                reg_read = 1'b1;
                state_d  = dec_halt ? S_HALT : S_EXECUTE;
            end

            S_EXECUTE: begin
                reg_read = 1'b1;
                pc_load  = take_pc_load;
                pc_inc   = ~take_pc_load;
                if (dec_writes) begin
                    state_d = S_WRITEBACK;
                end else begin
                    retire = 1'b1;
                end
            end

            S_WRITEBACK: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end

            S_HALT: begin
                // Only reset leaves HALT; run and step are deliberately ignored.
                halted = 1'b1;
            end

            default: begin
                // Unused encodings 6-7 fall back to IDLE on the next edge.
                state_d = S_IDLE;
            end
        endcase

        // A single-stepped instruction always ends in IDLE, even if run rose
        // meanwhile; IDLE then picks run up on the following cycle.
        if (retire) begin
            single_d = 1'b0;
            if (run && !single_q) begin
                state_d = S_FETCH;
                wait_d  = '0;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            single_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            single_q <= single_d;
            if (retire) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 16-bit CPU datapath. It steps each instruction through fetch, decode, execute and writeback. It drives the RAM read strobe, instruction-register load, register-file read/write enables and program-counter advance/load, and reacts to decode flags and the ALU `branch_check`. It supports free-running and single-step operation, halts on a decoded halt instruction, and counts retired instructions.

## Interface
- `FETCH_WAIT`, 1: RAM read latency in cycles; legal 1..4.
- `CNT_W`, 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; while high, instructions issue back-to-back.
- `step`  in  1  one-cycle pulse; issues exactly one instruction when idle and `run`=0.
- `dec_writes`  in  1  the decoded instruction writes a register.
- `dec_jump`  in  1  the decoded instruction is an unconditional jump.
- `dec_branch`  in  1  the decoded instruction is a conditional branch.
- `dec_halt`  in  1  the decoded instruction is HALT.
- `branch_check`  in  1  ALU branch condition, valid during EXECUTE.
- `ram_read`  out  1  RAM read strobe.
- `ir_load`  out  1  capture RAM output as the current instruction.
- `reg_read`  out  1  register-file read enable.
- `reg_write`  out  1  register-file write enable.
- `pc_inc`  out  1  PC advance by one.
- `pc_load`  out  1  PC load from the jump/branch address.
- `halted`  out  1  the sequencer is in HALT.
- `state`  out  3  current state encoding (debug).
- `instr_count`  out  CNT_W  number of retired instructions.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5. Codes 6–7 are unreachable and recover to IDLE on the next edge.
- **IDLE**: all strobes low.
  - `run`=1 → FETCH.
  - Else `step`=1 → FETCH, with the internal `single` flag set.
  - `step` is ignored in every other state.
- **FETCH**:
  - `ram_read`=1 for FETCH_WAIT cycles, counted by an internal wait counter that is cleared on entry.
  - `ir_load`=1 only in the last FETCH cycle; then → DECODE.
- **DECODE**: `reg_read`=1.
  - `dec_halt`=1 → HALT.
  - Otherwise → EXECUTE.
- **EXECUTE**: `reg_read`=1. Exactly one of `pc_load`/`pc_inc` is asserted for one cycle:
  - `pc_load`=1 if `dec_jump`, or if `dec_branch` & `branch_check`.
  - Otherwise `pc_inc`=1.
  - `dec_jump` has priority over `dec_branch`.
  - `dec_writes`=1 → WRITEBACK.
  - Otherwise the instruction retires.
- **WRITEBACK**: `reg_write`=1 for exactly one cycle; the instruction then retires.
- **Retire**:
  - `instr_count` increments by 1, wrapping from 2^CNT_W−1 to 0.
  - Next state is FETCH if `run`=1 and `single`=0; otherwise IDLE, with `single` cleared.
- **HALT**:
  - `halted`=1; all other strobes low; the PC is not advanced.
  - `run` and `step` are ignored; only reset exits HALT.
  - A HALT instruction is not counted.
- `run` falling mid-instruction: the current instruction completes and retires, then the sequencer goes to IDLE.
- `run` rising during a single-step: the step still ends in IDLE. The next cycle sees `run`=1 and enters FETCH.

## Timing
- Reset asserted, asynchronously: state=IDLE, wait counter=0, `single`=0, `instr_count`=0, and every output is 0.
- Reset mid-instruction aborts it with no further strobes. A `reg_write` in progress drops immediately.
- Reset deassertion is synchronised by the system. The first active edge evaluates IDLE.
- `ram_read`, `ir_load`, `reg_read`, `reg_write` and `halted` decode only from registered state and the wait counter, so they are glitch-free.
- `pc_inc`/`pc_load` additionally depend on the `dec_*` and `branch_check` inputs in the same EXECUTE cycle.
- The `dec_*` inputs must be stable from the DECODE cycle through the end of the instruction (they are derived from the loaded IR).
- Instruction latency in cycles, from the FETCH entry edge to the retire edge:
  - FETCH_WAIT+2 without writeback.
  - FETCH_WAIT+3 with writeback.
- `instr_count` updates on the edge that leaves EXECUTE or WRITEBACK.
- In `run` mode, back-to-back instructions have zero idle cycles. With FETCH_WAIT=1, a non-writing instruction takes 3 cycles.

## Test plan
- **Reset:** reset low for 3 cycles, asserted mid-WRITEBACK → `reg_write` drops within 0 cycles of reset; state=0, `instr_count`=0, all outputs 0.
- **Run, FETCH_WAIT=1:** `run`=1, 4 ALU ops with `dec_writes`=1 → state sequence 1,2,3,4 repeating; 16 cycles total; `instr_count`=4; four `pc_inc` and four `reg_write` pulses.
- **Branch/jump:** `dec_branch`=1 with `branch_check`=0 → `pc_inc`; with `branch_check`=1 → `pc_load`; `dec_jump`=1 and `dec_branch`=1 with `branch_check`=0 → `pc_load`.
- **Single-step, FETCH_WAIT=3:** `run`=0, one `step` pulse → `ram_read` high 3 cycles, `ir_load` on the 3rd, returns to IDLE after 5 cycles; a second `step` pulsed mid-instruction is ignored; `instr_count`=1.
- **Halt:** `dec_halt`=1 in DECODE → `halted`=1 on the next edge; no `pc_inc`; `run`/`step` toggled for 10 cycles → still halted; `instr_count` unchanged; reset → IDLE.
- **Counter wrap and run drop:** with CNT_W=4, 17 instructions → `instr_count`=1. Deassert `run` during FETCH → that instruction retires, then IDLE.
